vx_issue_scoreboard: RTL and testbench
======================================

# vx_issue_scoreboard

Register-hazard scoreboard and issue register in front of the GPR read / dispatch stage. Holds each decoded instruction until its source and destination registers have no outstanding write from an older in-flight instruction of the same warp, then registers it toward GPR read and dispatch. Writeback releases reservations; a stall counter and a deadlock watchdog provide perf and debug visibility.

## Interface
- NUM_WARPS, 4, warps tracked; WIDW = max(1, clog2(NUM_WARPS))
- NUM_REGS, 64, architectural registers per warp (int + fp); NRW = clog2(NUM_REGS)
- DATAW, 128, opaque payload carried with the instruction (uuid, tmask, PC, ex_type, op_type, op_mod, imm, ...)
- STALL_LIMIT, 100000, consecutive hazard-stall cycles before the deadlock flag sets
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  decoded instruction valid
- in_ready  out  1  instruction accepted this cycle
- in_wid  in  WIDW  warp id
- in_wb  in  1  instruction writes rd
- in_rd, in_rs1, in_rs2, in_rs3  in  NRW each  register indices
- in_used_rs  in  3  bit i set = rs(i+1) is read
- in_data  in  DATAW  payload
- out_valid  out  1  issued instruction valid
- out_ready  in  1  downstream (GPR read / dispatch) accepts
- out_wid, out_rd, out_wb, out_data  out  WIDW, NRW, 1, DATAW  registered copy of accepted input
- wb_valid  in  1  writeback event
- wb_wid, wb_rd  in  WIDW, NRW  writeback target
- wb_eop  in  1  last packet of the instruction; release only when set
- perf_stalls  out  32  cycles with in_valid=1 and hazard=1; wraps
- deadlock  out  1  sticky; set after STALL_LIMIT consecutive stall cycles

## Operation
- State: pending[NUM_WARPS][NUM_REGS], one bit per register.
- release = wb_valid & wb_eop; release targets pending[wb_wid][wb_rd].
- Effective pending (eff) = pending with the released bit cleared combinationally (same-cycle writeback bypass).
- hazard = in_valid & (OR over i of in_used_rs[i] & eff[in_wid][rs_i]) | (in_wb & eff[in_wid][in_rd]). The rd check is WAW.
- Register 0 is never pending: reservation of index 0 suppressed, hazard checks on index 0 return 0.
- in_ready = ~hazard & (~out_valid | out_ready); in_fire = in_valid & in_ready.
- On in_fire with in_wb=1 and in_rd≠0: set pending[in_wid][in_rd].
- Simultaneous release and reservation of the same bit: set wins (final = 1). Different bits: both apply.
- Release of a bit already 0: no effect, no error.
- Output register: load on in_fire; out_valid <= in_fire | (out_valid & ~out_ready). Payload holds while out_valid & ~out_ready.
- Watchdog: stall_cnt increments on in_valid & hazard, clears otherwise; deadlock sets when stall_cnt reaches STALL_LIMIT-1 while still stalling, cleared only by reset.

## Timing
- Reset: all pending = 0, out_valid = 0, out_* payload = 0, perf_stalls = 0, stall_cnt = 0, deadlock = 0. in_ready evaluates to ~hazard (= in_valid-independent 1 after reset, since nothing pending).
- Latency: in_fire at cycle N -> out_valid at N+1. Throughput 1/cycle when out_ready=1 and no hazard.
- Dependent back-to-back instruction (same warp, RAW on rd of previous): stalls from N+1 until writeback release; accepted in the same cycle as wb_eop (bypass).
- in_ready is combinational on in_* and wb_*; out_* are pure registers.
- in_valid may drop without acceptance (upstream warp switch); no state changes from a non-fired request.
- Reset mid-operation discards out register and all reservations; downstream must also be reset.

## Structure
- Shared package: scoreboard perf struct (stalls, deadlock), NRW/WIDW helper constants; reuse existing NR_BITS/NW_BITS defines.
- One natural sub-module: vx_sb_pending_bank (per-warp pending bitvector with set/clear/bypass read, 4 read ports), instantiated NUM_WARPS times or as one banked array.

## Test plan
- Reset, then w0 add rd=5 (wb=1) followed next cycle by w0 use rs1=5 -> second stalls, in_ready=0, perf_stalls increments each cycle; wb_valid=1,wb_eop=1,wb_wid=0,wb_rd=5 -> accepted that same cycle, out_valid next cycle.
- w0 reserves rd=5; w1 instruction reading rs1=5 -> no stall (per-warp isolation), issues 1 cycle later.
- Instruction with rd=0, wb=1 -> no reservation; next instruction reading rs1=0 issues without stall.
- Same cycle: release w0 r7 and in_fire of w0 instruction writing rd=7 -> pending[0][7]=1 afterwards; a following reader of r7 stalls.
- out_ready=0 for 3 cycles with stream of independent instructions -> in_ready=0, out_data stable, no reservation beyond the held instruction; out_ready=1 resumes 1/cycle.
- STALL_LIMIT=8, hold a hazard 8 cycles -> deadlock=1 on 8th cycle, stays 1 after release until reset.

Source files
------------

// File: rtl/vx_issue_scoreboard_pkg.sv
// Shared types and constants for the issue scoreboard.
package vx_issue_scoreboard_pkg;

    // Default index widths for the standard 4-warp / 64-register configuration.
    localparam int NW_BITS = 2;
    localparam int NR_BITS = 6;

    // Number of source ports checked against the pending table (rs1..rs3).
    localparam int NUM_SRC = 3;

    // Performance / debug visibility bundle.
    typedef struct packed {
        logic [31:0] stalls;
        logic        deadlock;
    } sb_perf_t;

endpackage

// File: rtl/vx_sb_pending_bank.sv
// One warp's pending-write bitvector with set/clear and four bypassed read ports.
module vx_sb_pending_bank #(
    parameter int NUM_REGS = 64,
    parameter int NRW      = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                set_en,
    input  logic [NRW-1:0]      set_idx,
    input  logic                clr_en,
    input  logic [NRW-1:0]      clr_idx,
    input  logic [3:0][NRW-1:0] rd_idx,
    output logic [3:0]          rd_pend
);

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;
    logic [NUM_REGS-1:0] eff;

    // Effective view: a same-cycle release is visible to readers; r0 never pending.
    always_comb begin
        eff = pend_q;
        if (clr_en) eff[clr_idx] = 1'b0;
        eff[0] = 1'b0;
    end

    // Next state: release first, then reservation, so a reservation wins on a collision.
    always_comb begin
        pend_d = eff;
        if (set_en && (set_idx != '0)) pend_d[set_idx] = 1'b1;
    end

    // Pending bit register.
    always_ff @(posedge clk) begin
        if (reset) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    // Read ports look at the bypassed view.
    always_comb begin
        for (int i = 0; i < 4; i++) rd_pend[i] = eff[rd_idx[i]];
    end

endmodule

// File: rtl/vx_issue_scoreboard.sv
// Register-hazard scoreboard plus issue register ahead of GPR read / dispatch.
module vx_issue_scoreboard
    import vx_issue_scoreboard_pkg::*;
#(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_REGS    = 64,
    parameter int DATAW       = 128,
    parameter int STALL_LIMIT = 100000,
    localparam int WIDW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int NRW  = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDW-1:0]  in_wid,
    input  logic             in_wb,
    input  logic [NRW-1:0]   in_rd,
    input  logic [NRW-1:0]   in_rs1,
    input  logic [NRW-1:0]   in_rs2,
    input  logic [NRW-1:0]   in_rs3,
    input  logic [2:0]       in_used_rs,
    input  logic [DATAW-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDW-1:0]  out_wid,
    output logic [NRW-1:0]   out_rd,
    output logic             out_wb,
    output logic [DATAW-1:0] out_data,
    input  logic             wb_valid,
    input  logic [WIDW-1:0]  wb_wid,
    input  logic [NRW-1:0]   wb_rd,
    input  logic             wb_eop,
    output logic [31:0]      perf_stalls,
    output logic             deadlock
);

    localparam int SCW = $clog2(STALL_LIMIT) + 1;

    logic                release_w;
    logic                hazard;
    logic                in_fire;
    logic [3:0][NRW-1:0] rd_idx;
    logic [3:0]          bank_pend [NUM_WARPS];
    logic [3:0]          pend;

    assign release_w = wb_valid & wb_eop;
    assign rd_idx    = {in_rd, in_rs3, in_rs2, in_rs1};

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_bank
        vx_sb_pending_bank #(
            .NUM_REGS (NUM_REGS),
            .NRW      (NRW)
        ) u_bank (
            .clk     (clk),
            .reset   (reset),
            .set_en  (in_fire & in_wb & (in_wid == WIDW'(w))),
            .set_idx (in_rd),
            .clr_en  (release_w & (wb_wid == WIDW'(w))),
            .clr_idx (wb_rd),
            .rd_idx  (rd_idx),
            .rd_pend (bank_pend[w])
        );
    end

    // Hazard check against the issuing warp's bank: RAW on used sources, WAW on rd.
    always_comb begin
        pend   = bank_pend[in_wid];
        hazard = in_valid & ((|(in_used_rs & pend[NUM_SRC-1:0])) | (in_wb & pend[3]));
    end

    assign in_ready = ~hazard & (~out_valid | out_ready);
    assign in_fire  = in_valid & in_ready;

    logic             out_valid_q;
    logic [WIDW-1:0]  out_wid_q;
    logic [NRW-1:0]   out_rd_q;
    logic             out_wb_q;
    logic [DATAW-1:0] out_data_q;

    // Issue register: loads on acceptance, holds while downstream back-pressures.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_wid_q   <= '0;
            out_rd_q    <= '0;
            out_wb_q    <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= in_fire | (out_valid_q & ~out_ready);
            if (in_fire) begin
                out_wid_q  <= in_wid;
                out_rd_q   <= in_rd;
                out_wb_q   <= in_wb;
                out_data_q <= in_data;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_wid   = out_wid_q;
    assign out_rd    = out_rd_q;
    assign out_wb    = out_wb_q;
    assign out_data  = out_data_q;

    sb_perf_t       perf_q, perf_d;
    logic [SCW-1:0] stall_cnt_q, stall_cnt_d;

    // Stall counter (wrapping) and watchdog; the watchdog count saturates at its limit.
    always_comb begin
        perf_d      = perf_q;
        stall_cnt_d = '0;
        if (hazard) begin
            perf_d.stalls = perf_q.stalls + 32'd1;
            if (stall_cnt_q == SCW'(STALL_LIMIT - 1)) begin
                perf_d.deadlock = 1'b1;
                stall_cnt_d     = stall_cnt_q;
            end else begin
                stall_cnt_d = stall_cnt_q + SCW'(1);
            end
        end
    end

    // Perf / watchdog state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            perf_q      <= perf_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_stalls = perf_q.stalls;
    assign deadlock    = perf_q.deadlock;

endmodule

// File: tb/tb_vx_issue_scoreboard.sv
// Directed bench for vx_issue_scoreboard: vector table plus hand-written corner sequences.
module tb_vx_issue_scoreboard;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_wid;
    logic         in_wb;
    logic [5:0]   in_rd, in_rs1, in_rs2, in_rs3;
    logic [2:0]   in_used_rs;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_wid;
    logic [5:0]   out_rd;
    logic         out_wb;
    logic [127:0] out_data;
    logic         wb_valid;
    logic [1:0]   wb_wid;
    logic [5:0]   wb_rd;
    logic         wb_eop;
    logic [31:0]  perf_stalls;
    logic         deadlock;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vx_issue_scoreboard #(
        .NUM_WARPS   (4),
        .NUM_REGS    (64),
        .DATAW       (128),
        .STALL_LIMIT (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_wid      (in_wid),
        .in_wb       (in_wb),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_rs3      (in_rs3),
        .in_used_rs  (in_used_rs),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_wid     (out_wid),
        .out_rd      (out_rd),
        .out_wb      (out_wb),
        .out_data    (out_data),
        .wb_valid    (wb_valid),
        .wb_wid      (wb_wid),
        .wb_rd       (wb_rd),
        .wb_eop      (wb_eop),
        .perf_stalls (perf_stalls),
        .deadlock    (deadlock)
    );

    typedef struct {
        logic       iv;
        logic [1:0] wid;
        logic       wb;
        logic [5:0] rd, rs1, rs2, rs3;
        logic [2:0] used;
        logic [7:0] data;
        logic       wbv;
        logic [1:0] wbwid;
        logic [5:0] wbrd;
        logic       eop;
        logic       e_rdy;
        logic       e_ov;
        logic [7:0] e_od;
        logic [31:0] e_perf;
    } vec_t;

    localparam int NVEC = 23;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic iv, input logic [1:0] wid, input logic wb,
                                input logic [5:0] rd, input logic [5:0] rs1,
                                input logic [5:0] rs2, input logic [5:0] rs3,
                                input logic [2:0] used, input logic [7:0] data,
                                input logic wbv, input logic [1:0] wbwid,
                                input logic [5:0] wbrd, input logic eop,
                                input logic e_rdy, input logic e_ov,
                                input logic [7:0] e_od, input logic [31:0] e_perf);
        vec_t v;
        v.iv = iv; v.wid = wid; v.wb = wb; v.rd = rd;
        v.rs1 = rs1; v.rs2 = rs2; v.rs3 = rs3; v.used = used; v.data = data;
        v.wbv = wbv; v.wbwid = wbwid; v.wbrd = wbrd; v.eop = eop;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_od = e_od; v.e_perf = e_perf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; in_wid = 0; in_wb = 0; in_rd = 0;
        in_rs1 = 0; in_rs2 = 0; in_rs3 = 0; in_used_rs = 0; in_data = '0;
        wb_valid = 0; wb_wid = 0; wb_rd = 0; wb_eop = 0;
        out_ready = 1;
    endtask

    task automatic drive_instr(input logic [1:0] wid, input logic wb, input logic [5:0] rd,
                               input logic [5:0] rs1, input logic [2:0] used,
                               input logic [7:0] data);
        in_valid = 1; in_wid = wid; in_wb = wb; in_rd = rd;
        in_rs1 = rs1; in_rs2 = 0; in_rs3 = 0; in_used_rs = used;
        in_data = {120'b0, data};
    endtask

    initial begin
        tbl[0]  = mk(1,0,1,5, 0,0,0,3'b000, 8'd1,  0,0,0,0, 1,1,8'd1,  0);
        tbl[1]  = mk(1,0,0,0, 5,0,0,3'b001, 8'd2,  0,0,0,0, 0,0,8'd0,  1);
        tbl[2]  = mk(1,0,0,0, 5,0,0,3'b001, 8'd2,  0,0,0,0, 0,0,8'd0,  2);
        tbl[3]  = mk(1,0,0,0, 5,0,0,3'b001, 8'd2,  1,0,5,1, 1,1,8'd2,  2);
        tbl[4]  = mk(1,0,1,5, 0,0,0,3'b000, 8'd3,  0,0,0,0, 1,1,8'd3,  2);
        tbl[5]  = mk(1,1,0,0, 5,0,0,3'b001, 8'd4,  0,0,0,0, 1,1,8'd4,  2);
        tbl[6]  = mk(1,0,0,0, 0,0,5,3'b100, 8'd5,  0,0,0,0, 0,0,8'd0,  3);
        tbl[7]  = mk(1,0,0,0, 0,0,5,3'b100, 8'd5,  1,0,5,0, 0,0,8'd0,  4);
        tbl[8]  = mk(0,0,0,0, 0,0,0,3'b000, 8'd0,  1,0,5,1, 1,0,8'd0,  4);
        tbl[9]  = mk(1,2,1,0, 0,0,0,3'b000, 8'd6,  0,0,0,0, 1,1,8'd6,  4);
        tbl[10] = mk(1,2,1,0, 0,0,0,3'b001, 8'd7,  0,0,0,0, 1,1,8'd7,  4);
        tbl[11] = mk(1,0,1,7, 0,0,0,3'b000, 8'd8,  0,0,0,0, 1,1,8'd8,  4);
        tbl[12] = mk(1,0,1,7, 0,0,0,3'b000, 8'd9,  1,0,7,1, 1,1,8'd9,  4);
        tbl[13] = mk(1,0,0,0, 7,0,0,3'b001, 8'd10, 0,0,0,0, 0,0,8'd0,  5);
        tbl[14] = mk(1,0,0,0, 7,0,0,3'b001, 8'd10, 1,0,7,1, 1,1,8'd10, 5);
        tbl[15] = mk(1,3,1,9, 0,0,0,3'b000, 8'd11, 0,0,0,0, 1,1,8'd11, 5);
        tbl[16] = mk(1,3,1,9, 0,0,0,3'b000, 8'd12, 0,0,0,0, 0,0,8'd0,  6);
        tbl[17] = mk(0,0,0,0, 0,0,0,3'b000, 8'd0,  0,0,0,0, 1,0,8'd0,  6);
        tbl[18] = mk(0,0,0,0, 0,0,0,3'b000, 8'd0,  1,3,9,1, 1,0,8'd0,  6);
        tbl[19] = mk(1,1,1,3, 0,0,0,3'b000, 8'd13, 0,0,0,0, 1,1,8'd13, 6);
        tbl[20] = mk(1,1,0,0, 0,3,0,3'b010, 8'd14, 0,0,0,0, 0,0,8'd0,  7);
        tbl[21] = mk(1,1,0,0, 0,3,0,3'b000, 8'd14, 0,0,0,0, 1,1,8'd14, 7);
        tbl[22] = mk(0,0,0,0, 0,0,0,3'b000, 8'd0,  1,1,3,1, 1,0,8'd0,  7);

        // Reset
        idle();
        reset = 1;
        tick(); tick();
        reset = 0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_perf", perf_stalls, 0);
        chk("rst_deadlock", deadlock, 0);
        in_valid = 1; in_rs1 = 5; in_used_rs = 3'b001;
        #1;
        chk("rst_in_ready", in_ready, 1);
        idle();
        tick();

        // Vector table
        for (int i = 0; i < NVEC; i++) begin
            in_valid = tbl[i].iv; in_wid = tbl[i].wid; in_wb = tbl[i].wb;
            in_rd = tbl[i].rd; in_rs1 = tbl[i].rs1; in_rs2 = tbl[i].rs2;
            in_rs3 = tbl[i].rs3; in_used_rs = tbl[i].used;
            in_data = {120'b0, tbl[i].data};
            wb_valid = tbl[i].wbv; wb_wid = tbl[i].wbwid;
            wb_rd = tbl[i].wbrd; wb_eop = tbl[i].eop;
            out_ready = 1;
            #1;
            chk($sformatf("row%0d_in_ready", i), in_ready, tbl[i].e_rdy);
            tick();
            chk($sformatf("row%0d_out_valid", i), out_valid, tbl[i].e_ov);
            if (tbl[i].e_ov) begin
                chk($sformatf("row%0d_out_data", i), out_data, {120'b0, tbl[i].e_od});
                chk($sformatf("row%0d_out_rd", i), out_rd, tbl[i].rd);
                chk($sformatf("row%0d_out_wid", i), out_wid, tbl[i].wid);
            end
            chk($sformatf("row%0d_perf", i), perf_stalls, tbl[i].e_perf);
        end
        idle();

        // Backpressure: held instruction stays, nothing else reserves
        out_ready = 0;
        drive_instr(0, 1, 10, 0, 3'b000, 8'h20);
        #1;
        chk("bp_accept_ready", in_ready, 1);
        tick();
        chk("bp_accept_ov", out_valid, 1);
        drive_instr(0, 1, 11, 0, 3'b000, 8'h21);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp_hold%0d_ready", k), in_ready, 0);
            tick();
            chk($sformatf("bp_hold%0d_ov", k), out_valid, 1);
            chk($sformatf("bp_hold%0d_data", k), out_data, 128'h20);
        end
        drive_instr(0, 0, 0, 11, 3'b001, 8'h00);
        tick();
        chk("bp_no_resv_r11", perf_stalls, 7);
        drive_instr(0, 0, 0, 10, 3'b001, 8'h00);
        tick();
        chk("bp_resv_r10", perf_stalls, 8);
        out_ready = 1;
        drive_instr(0, 1, 11, 0, 3'b000, 8'h21);
        #1;
        chk("bp_resume_ready", in_ready, 1);
        tick();
        chk("bp_resume_data", out_data, 128'h21);
        drive_instr(0, 1, 12, 0, 3'b000, 8'h22);
        #1;
        chk("bp_resume2_ready", in_ready, 1);
        tick();
        chk("bp_resume2_data", out_data, 128'h22);
        idle();
        tick();
        chk("bp_drain_ov", out_valid, 0);

        // Watchdog: hold a RAW hazard on w0 r10 for STALL_LIMIT cycles
        drive_instr(0, 0, 0, 10, 3'b001, 8'h30);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("wd_cycle%0d", k), deadlock, (k == 8));
        end
        chk("wd_perf", perf_stalls, 16);
        wb_valid = 1; wb_wid = 0; wb_rd = 10; wb_eop = 1;
        #1;
        chk("wd_release_ready", in_ready, 1);
        tick();
        chk("wd_release_data", out_data, 128'h30);
        chk("wd_sticky1", deadlock, 1);
        idle();
        tick();
        chk("wd_sticky2", deadlock, 1);

        // Mid-operation reset clears everything including reservations
        drive_instr(0, 1, 20, 0, 3'b000, 8'h40);
        tick();
        idle();
        reset = 1;
        tick();
        reset = 0;
        #1;
        chk("rst2_deadlock", deadlock, 0);
        chk("rst2_perf", perf_stalls, 0);
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_out_data", out_data, 0);
        drive_instr(0, 0, 0, 11, 3'b001, 8'h50);
        #1;
        chk("rst2_in_ready", in_ready, 1);
        tick();
        chk("rst2_issue", out_data, 128'h50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
